// File: rtl/pc_ctrl_pkg.sv
// Shared types for the PC sequencing controller: state encoding, opcode classes,
// PC width and the branch-taken rule.
package pc_ctrl_pkg;
  localparam int PC_W      = 8;
  localparam int OP_CLS_W  = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_FLUSH, S_HALT, S_ERR
  } state_t;

  typedef enum logic [OP_CLS_W-1:0] {
    OP_ALU  = 2'b00,
    OP_BEQ  = 2'b01,
    OP_JMP  = 2'b10,
    OP_HALT = 2'b11
  } op_t;

  function automatic logic is_taken(input op_t op, input logic z);
    return (op == OP_JMP) || (op == OP_BEQ && z);
  endfunction
endpackage

// File: rtl/pc_seq_timer.sv
// Loadable up/down counter with a terminal-count flag; used for the fetch
// timeout (counting up) and for the post-branch flush bubbles (counting down).
module pc_seq_timer #(
  parameter int           W    = 8,
  parameter bit           UP   = 1'b1,
  parameter logic [W-1:0] TERM = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         term
);
  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)     count <= '0;
    else if (load) count <= load_val;
    else if (en)   count <= UP ? count + 1'b1 : count - 1'b1;
  end

  assign term = (count == TERM);
endmodule

// File: rtl/pc_seq_ctrl.sv
// Fetch/decode sequencer driving PC enable and PCSrc. Optional performance
// counters (instr_cnt, taken_cnt) are built when PC_SEQ_CTRL_PERF_EN is defined.
module pc_seq_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int OP_W    = 2,
  parameter int TIMEOUT = 15,
  parameter int BUBBLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            fetch_req,
  input  logic            instr_valid,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  output logic            pc_en,
  output logic            pc_src,
  output logic            busy,
  output logic            halted,
  output logic            err
`ifdef PC_SEQ_CTRL_PERF_EN
  ,
  output logic [15:0]     instr_cnt,
  output logic [15:0]     taken_cnt
`endif
);
  localparam bit HAS_BUB = (BUBBLES > 0);

  state_t state;
  op_t    op_q;
  logic   zero_q;
  logic   tmr_term, bub_term;
  op_t    op_in;

  assign op_in = op_t'(opcode);

  // Timer holds zero outside WAIT so every fetch starts a fresh timeout window.
  pc_seq_timer #(.W(PC_W), .UP(1'b1), .TERM(PC_W'(TIMEOUT - 1))) u_tmo (
    .clk(clk), .reset(reset),
    .load(state != S_WAIT || instr_valid), .load_val('0),
    .en(state == S_WAIT), .term(tmr_term)
  );

  pc_seq_timer #(.W(3), .UP(1'b0), .TERM(3'd1)) u_bub (
    .clk(clk), .reset(reset),
    .load(state == S_EXEC), .load_val(3'(BUBBLES)),
    .en(state == S_FLUSH), .term(bub_term)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      fetch_req <= 1'b0;
      pc_en     <= 1'b0;
      pc_src    <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
      err       <= 1'b0;
      op_q      <= OP_ALU;
      zero_q    <= 1'b0;
    end else begin
      fetch_req <= 1'b0;
      pc_en     <= 1'b0;
      pc_src    <= 1'b0;
      unique case (state)
        S_IDLE: if (start) begin
          state     <= S_FETCH;
          fetch_req <= 1'b1;
          busy      <= 1'b1;
        end
        S_FETCH: state <= S_WAIT;
        S_WAIT: begin
          // A response on the terminal timeout cycle still counts.
          if (instr_valid) begin
            op_q   <= op_in;
            zero_q <= zero;
            if (op_in == OP_HALT) begin
              state  <= S_HALT;
              busy   <= 1'b0;
              halted <= 1'b1;
            end else begin
              state  <= S_EXEC;
              pc_en  <= 1'b1;
              pc_src <= is_taken(op_in, zero);
            end
          end else if (tmr_term) begin
            state <= S_ERR;
            busy  <= 1'b0;
            err   <= 1'b1;
          end
        end
        S_EXEC: begin
          if (HAS_BUB && is_taken(op_q, zero_q)) begin
            state <= S_FLUSH;
          end else begin
            state     <= S_FETCH;
            fetch_req <= 1'b1;
          end
        end
        S_FLUSH: if (bub_term) begin
          state     <= S_FETCH;
          fetch_req <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef PC_SEQ_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_cnt <= '0;
      taken_cnt <= '0;
    end else if (state == S_EXEC) begin
      if (instr_cnt != 16'hFFFF)           instr_cnt <= instr_cnt + 16'd1;
      if (pc_src && taken_cnt != 16'hFFFF) taken_cnt <= taken_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Randomized bench for pc_seq_ctrl: a transaction-level memory model predicts
// per-instruction timing (fetch, wait, exec, bubbles) from the opcode rules.
module tb_pc_seq_ctrl;
  localparam int TIMEOUT = 15;
  localparam int BUBBLES = 2;

  logic       clk = 1'b0;
  logic       reset, start, instr_valid, zero;
  logic [1:0] opcode;
  logic       fetch_req, pc_en, pc_src, busy, halted, err;
`ifdef PC_SEQ_CTRL_PERF_EN
  logic [15:0] instr_cnt, taken_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int m_instr = 0;
  int m_taken = 0;

  pc_seq_ctrl #(.OP_W(2), .TIMEOUT(TIMEOUT), .BUBBLES(BUBBLES)) dut (
    .clk(clk), .reset(reset), .start(start), .fetch_req(fetch_req),
    .instr_valid(instr_valid), .opcode(opcode), .zero(zero),
    .pc_en(pc_en), .pc_src(pc_src), .busy(busy), .halted(halted), .err(err)
`ifdef PC_SEQ_CTRL_PERF_EN
    , .instr_cnt(instr_cnt), .taken_cnt(taken_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Inputs the DUT must ignore in the current state.
  task automatic stray();
    instr_valid = 1'($urandom_range(0, 1));
    opcode      = 2'($urandom_range(0, 3));
    zero        = 1'($urandom_range(0, 1));
    start       = 1'($urandom_range(0, 1));
  endtask

  task automatic chk_cnt(input string tag);
`ifdef PC_SEQ_CTRL_PERF_EN
    chk({tag, "/instr_cnt"}, instr_cnt, m_instr);
    chk({tag, "/taken_cnt"}, taken_cnt, m_taken);
`endif
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "/outs"}, {fetch_req, pc_en, pc_src, busy, halted, err}, 6'b0);
    chk_cnt(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; start = 1'b0; instr_valid = 1'b0;
    m_instr = 0; m_taken = 0;
    step();
    chk_idle(tag);
    reset = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Entered in the FETCH cycle; d extra WAIT cycles precede the response.
  task automatic run_instr(input int op, input bit z, input int d);
    bit taken;
    chk("fetch/req", {fetch_req, pc_en, pc_src, busy}, 4'b1001);
    stray();
    step();
    for (int w = 0; w < d; w++) begin
      chk("wait/outs", {fetch_req, pc_en, pc_src, busy, err}, 5'b00010);
      stray(); instr_valid = 1'b0;
      step();
    end
    chk("wait/last", {fetch_req, pc_en, busy, err}, 4'b0010);
    start = 1'b0; instr_valid = 1'b1; opcode = 2'(op); zero = z;
    step();
    stray();
    if (op == 3) begin
      chk("halt/outs", {halted, busy, pc_en, pc_src, fetch_req, err}, 6'b100000);
      instr_valid = 1'b0;
      return;
    end
    taken = (op == 2) || (op == 1 && z);
    m_instr++;
    if (taken) m_taken++;
    chk("exec/pc_en", pc_en, 1'b1);
    chk("exec/pc_src", pc_src, taken);
    step();
    if (taken) begin
      for (int b = 0; b < BUBBLES; b++) begin
        chk("flush/outs", {fetch_req, pc_en, pc_src, busy}, 4'b0001);
        stray();
        step();
      end
    end
    chk_cnt("post_exec");
    instr_valid = 1'b0; start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; instr_valid = 1'b0; opcode = 2'b00; zero = 1'b0;
    step();
    do_reset("reset");
    step();
    chk_idle("idle_hold");

    // Directed opcode classes, zero-wait memory
    go();
    run_instr(0, 0, 0);
    run_instr(0, 1, 0);
    run_instr(1, 1, 0);
    run_instr(1, 0, 0);
    run_instr(2, 0, 0);
    run_instr(2, 1, 1);
    // Response on the last allowed WAIT cycle wins over the timeout
    run_instr(0, 0, TIMEOUT - 1);
    chk("late_valid/err", err, 1'b0);

    // Random program with random memory latency
    for (int i = 0; i < 40; i++) begin
      int d;
      d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TIMEOUT - 1))
                                      : int'($urandom_range(0, 2));
      run_instr(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), d);
    end

    // HALT is sticky and ignores start
    run_instr(3, 0, int'($urandom_range(0, 3)));
    for (int i = 0; i < 6; i++) begin
      stray(); start = 1'b1;
      step();
      chk("halt/sticky", {halted, busy, pc_en, fetch_req}, 4'b1000);
    end
    chk_cnt("halt/cnt");
    do_reset("halt_reset");

    // Fetch timeout
    go();
    chk("tmo/fetch", fetch_req, 1'b1);
    instr_valid = 1'b0;
    step();
    for (int w = 1; w < TIMEOUT; w++) begin
      chk("tmo/wait", {busy, err}, 2'b10);
      step();
    end
    chk("tmo/last_wait", {busy, err}, 2'b10);
    step();
    chk("tmo/err", {err, busy, halted, fetch_req, pc_en}, 5'b10000);
    for (int i = 0; i < 5; i++) begin
      stray();
      step();
      chk("tmo/sticky", {err, busy, fetch_req, pc_en}, 4'b1000);
    end
    do_reset("err_reset");

    // Reset during FLUSH
    go();
    step();
    instr_valid = 1'b1; opcode = 2'b10; zero = 1'b0;
    step();
    instr_valid = 1'b0;
    chk("rflush/exec", {pc_en, pc_src}, 2'b11);
    step();
    chk("rflush/in_flush", {fetch_req, pc_en, busy}, 3'b001);
    do_reset("rflush");
    step();
    chk_idle("rflush/after");

    // Reset during WAIT
    go();
    step();
    step();
    chk("rwait/in_wait", {busy, fetch_req, pc_en}, 3'b100);
    do_reset("rwait");
    step();
    chk_idle("rwait/after");

`ifdef PC_SEQ_CTRL_PERF_EN
    go();
    for (int i = 0; i < 5; i++) run_instr(0, 1'($urandom_range(0, 1)), 0);
    for (int i = 0; i < 2; i++) run_instr(2, 1'($urandom_range(0, 1)), 0);
    chk("perf/instr7", instr_cnt, 16'd7);
    chk("perf/taken2", taken_cnt, 16'd2);
    do_reset("perf_reset");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
Sequencing controller for the 8-bit program counter. Handshakes instruction fetch with instruction memory and decodes a 2-bit opcode class. Drives the PC's update enable and its branch-select (PCSrc) input. Inserts flush bubbles after taken branches, and stops on HALT or on a fetch timeout.

Parameters:
OP_W, 2, opcode class field width (fixed encoding below)
TIMEOUT, 15, max cycles waiting for instr_valid before error (1..255)
BUBBLES, 2, flush cycles after a taken branch (0..7)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high; dominates all other inputs
start  in  1  begin sequencing from IDLE
fetch_req  out  1  one-cycle fetch request to instruction memory
instr_valid  in  1  instruction memory response valid
opcode  in  OP_W  class of fetched instruction, sampled with instr_valid
zero  in  1  ALU zero flag, sampled with instr_valid
pc_en  out  1  PC update enable (one cycle per executed instruction)
pc_src  out  1  to PC PCSrc: 1 = PC+immediate, 0 = PC+1
busy  out  1  state not IDLE/HALT/ERR
halted  out  1  HALT state
err  out  1  fetch timeout occurred

Behaviour:
- Opcode classes: 00 ALU (no branch), 01 BEQ (taken iff zero=1), 10 JMP (always taken), 11 HALT.
- States:
  - IDLE -> FETCH on start.
  - FETCH: fetch_req=1 for exactly one cycle -> WAIT.
  - WAIT:
    - If instr_valid: latch opcode/zero, clear timer; -> EXEC, or -> HALT if opcode=11.
    - Else timer++; at timer==TIMEOUT -> ERR.
  - EXEC: pc_en=1; pc_src=taken.
    - taken and BUBBLES>0 -> FLUSH.
    - Otherwise -> FETCH.
  - FLUSH: bubble counter counts down from BUBBLES; fetch_req=0, pc_en=0; at count 1 -> FETCH.
  - HALT, ERR: sticky until reset.
- Outputs:
  - fetch_req, pc_en, pc_src, busy, halted and err are decoded from registered state/latched flags only (Moore). No combinational input-to-output path.
  - pc_src=0 whenever pc_en=0.
- Reset values: state IDLE; all outputs 0; timer, bubble counter and latched opcode/zero cleared.
- Reset mid-operation (any state, incl. HALT/ERR): IDLE on the next edge. No pc_en is issued that cycle.
- start is ignored outside IDLE. instr_valid is ignored outside WAIT. A stray instr_valid in FETCH does not advance.
- instr_valid on the same edge the timer reaches TIMEOUT: the valid wins (-> EXEC/HALT), not ERR.
- HALT does not assert pc_en; the PC holds the HALT instruction address.
- Latency, ALU instruction with zero-wait memory: FETCH, WAIT, EXEC = 3 cycles per instruction. A taken branch adds BUBBLES cycles.

Optional Feature:
PC_SEQ_CTRL_PERF_EN
- Defined: adds outputs instr_cnt[15:0] and taken_cnt[15:0].
  - instr_cnt increments on each EXEC; taken_cnt increments on each EXEC with pc_src=1.
  - Both saturate at 16'hFFFF, clear on reset, and hold in HALT/ERR.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package pc_ctrl_pkg: state enum (IDLE, FETCH, WAIT, EXEC, FLUSH, HALT, ERR), opcode class enum/constants (OP_ALU, OP_BEQ, OP_JMP, OP_HALT), PC width constant 8.
- One natural sub-module: pc_seq_timer, a loadable down/up counter with terminal flag. It is instantiated twice, once for the WAIT timeout and once for the FLUSH bubbles.
- FSM and decode stay in pc_seq_ctrl.

Test Plan:
- Reset held 2 cycles, then start=1, memory answers ALU (00) one cycle after each fetch_req -> fetch_req every 3rd cycle; pc_en=1 with pc_src=0 each EXEC; busy=1.
- BEQ (01) with zero=1, BUBBLES=2 -> pc_en=1, pc_src=1 in EXEC; next 2 cycles fetch_req=0, pc_en=0; fetch_req resumes on the 3rd cycle. Same opcode with zero=0 -> pc_src=0, no bubbles.
- JMP (10) with zero=0 -> pc_src=1 (taken regardless of zero).
- Opcode 11 -> halted=1, busy=0, pc_en never asserts again. Further start pulses are ignored until reset=1, which returns IDLE with all outputs 0.
- No instr_valid for 15 cycles in WAIT -> err=1 on cycle 15, sticky. Variant: instr_valid arrives on cycle 15 -> EXEC, err=0.
- reset=1 asserted during FLUSH and again during WAIT -> IDLE next edge, counters cleared, no pc_en pulse. With PC_SEQ_CTRL_PERF_EN: 5 ALU + 2 taken JMP -> instr_cnt=7, taken_cnt=2.
